// File: rtl/spi_slave.sv
// SPI mode 0 slave with clk-domain synchronisers and an IDLE/ACTIVE FSM.
// Define SPI_SLAVE_LSB_FIRST_EN to shift both directions LSB first (default MSB first).
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_csSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sclkPrev;
  logic                   r_csPrev;
  logic [7:0]             r_shiftTx;
  logic [7:0]             r_shiftRx;
  logic [7:0]             r_txBuf;
  logic [7:0]             r_rxData;
  logic [2:0]             r_bitCnt;
  logic                   r_rxValid;
  logic                   r_busy;

  logic       w_sclkS;
  logic       w_csS;
  logic       w_mosiS;
  logic       w_sclkRise;
  logic       w_sclkFall;
  logic       w_csFall;
  logic       w_csRise;
  logic [7:0] w_txNext;
  logic [7:0] w_rxNext;
  logic [7:0] w_txShift;
  logic       w_txBit;

  assign w_sclkS    = r_sclkSync[SYNC_STAGES-1];
  assign w_csS      = r_csSync[SYNC_STAGES-1];
  assign w_mosiS    = r_mosiSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclkS & ~r_sclkPrev;
  assign w_sclkFall = ~w_sclkS & r_sclkPrev;
  assign w_csFall   = ~w_csS & r_csPrev;
  assign w_csRise   = w_csS & ~r_csPrev;
  // A strobe coinciding with a reload goes straight into the shifter
  assign w_txNext   = tx_load ? tx_data : r_txBuf;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_rxNext  = {w_mosiS, r_shiftRx[7:1]};
  assign w_txShift = {1'b0, r_shiftTx[7:1]};
  assign w_txBit   = r_shiftTx[0];
`else
  assign w_rxNext  = {r_shiftRx[6:0], w_mosiS};
  assign w_txShift = {r_shiftTx[6:0], 1'b0};
  assign w_txBit   = r_shiftTx[7];
`endif

  assign miso     = (r_state == ACTIVE) & w_txBit;
  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;
  assign busy     = r_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclkSync <= '0;
      r_csSync   <= '1;
      r_mosiSync <= '0;
      r_sclkPrev <= 1'b0;
      r_csPrev   <= 1'b1;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk};
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], cs_n};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
      r_sclkPrev <= w_sclkS;
      r_csPrev   <= w_csS;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_shiftTx <= 8'h00;
      r_shiftRx <= 8'h00;
      r_txBuf   <= 8'h00;
      r_rxData  <= 8'h00;
      r_bitCnt  <= 3'd0;
      r_rxValid <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      if (tx_load) r_txBuf <= tx_data;
      case (r_state)
        IDLE: begin
          if (w_csFall) begin
            r_state   <= ACTIVE;
            r_busy    <= 1'b1;
            r_shiftTx <= w_txNext;
            r_bitCnt  <= 3'd0;
          end
        end
        ACTIVE: begin
          if (w_csRise) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_bitCnt <= 3'd0;
          end else begin
            if (w_sclkRise) begin
              r_shiftRx <= w_rxNext;
              r_bitCnt  <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                r_rxData  <= w_rxNext;
                r_rxValid <= 1'b1;
              end
            end
            // bit_cnt already wrapped to 0 means this fall starts a new byte
            if (w_sclkFall) begin
              if (r_bitCnt == 3'd0) r_shiftTx <= w_txNext;
              else                  r_shiftTx <= w_txShift;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios plus random SPI transfers
// checked every clk against a transaction-level model of expected rx/busy/miso.
module tb_spi_slave;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  typedef struct {
    int         cycle;
    logic [7:0] data;
  } rxExp_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rxPulses = 0;
  rxExp_t     rxQ[$];
  logic       csHist[$];
  logic [7:0] mdlRxData = 8'h00;
  logic [7:0] mdlTxBuf = 8'h00;
  logic [7:0] mRx[3];
  logic       mFirstBit;

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: rx events land SYNC+1 clks after the master's sclk rise,
  // busy follows cs_n as seen SYNC clk edges earlier, miso must be 0 while not busy.
  initial begin : compareProc
    logic expValid;
    logic expBusy;
    forever begin
      @(posedge clk);
      cyc++;
      csHist.push_back(reset_n ? cs_n : 1'b1);
      if (csHist.size() > 8) void'(csHist.pop_front());
      #1;
      if (!reset_n) begin
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_miso", {31'd0, miso}, 32'd0);
        checkOutput("rst_rx_data", {24'd0, rx_data}, 32'd0);
      end else begin
        expValid = 1'b0;
        if (rxQ.size() > 0 && rxQ[0].cycle == cyc) begin
          expValid  = 1'b1;
          mdlRxData = rxQ[0].data;
          void'(rxQ.pop_front());
        end
        expBusy = (csHist.size() > SYNC) ? !csHist[csHist.size()-1-SYNC] : 1'b0;
        checkOutput("rx_valid", {31'd0, rx_valid}, {31'd0, expValid});
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, mdlRxData});
        checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
        if (!expBusy) checkOutput("miso_idle", {31'd0, miso}, 32'd0);
        if (rx_valid === 1'b1) rxPulses++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic loadTx(input logic [7:0] v);
    @(negedge clk);
    tx_data  = v;
    tx_load  = 1'b1;
    mdlTxBuf = v;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // One SPI mode-0 master transaction; optional abort by cs_n rise or by reset.
  task automatic applyStimulus(input int nBytes, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int half, input int abortBits,
                               input logic rstAbort, input logic midLoad, input logic [7:0] midVal);
    logic [7:0] bytes[3];
    logic [7:0] expTx;
    logic [7:0] rcv;
    rxExp_t     e;
    int         bits;
    int         idx;
    logic       stop;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    bits = 0;
    stop = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    for (int k = 0; k < nBytes && !stop; k++) begin
      expTx = mdlTxBuf;
      rcv   = 8'h00;
      for (int i = 0; i < 8 && !stop; i++) begin
        if (abortBits > 0 && bits == abortBits) begin
          stop = 1'b1;
        end else begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
          idx = i;
`else
          idx = 7 - i;
`endif
          mosi = bytes[k][idx];
          repeat (half) @(negedge clk);
          sclk = 1'b1;
          rcv[idx] = miso;
          if (k == 0 && i == 0) mFirstBit = miso;
          if (i == 7) begin
            e.cycle = cyc + SYNC + 1;
            e.data  = bytes[k];
            rxQ.push_back(e);
          end
          if (midLoad && k == 0 && i == 3) begin
            tx_data  = midVal;
            tx_load  = 1'b1;
            mdlTxBuf = midVal;
          end
          @(negedge clk);
          tx_load = 1'b0;
          repeat (half - 1) @(negedge clk);
          sclk = 1'b0;
          bits++;
        end
      end
      if (!stop) begin
        checkOutput("miso_byte", {24'd0, rcv}, {24'd0, expTx});
        mRx[k] = rcv;
      end
    end
    if (stop && rstAbort) begin
      reset_n   = 1'b0;
      cs_n      = 1'b1;
      sclk      = 1'b0;
      mosi      = 1'b0;
      mdlRxData = 8'h00;
      mdlTxBuf  = 8'h00;
      rxQ.delete();
      #1;
      checkOutput("async_rst_miso", {31'd0, miso}, 32'd0);
      checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("async_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      checkOutput("async_rst_rx_data", {24'd0, rx_data}, 32'h00);
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
    end else begin
      repeat (half) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
    end
    repeat (half + SYNC + 4) @(negedge clk);
  endtask

  initial begin : mainProc
    int p;
    int n;
    int half;
    int abortBits;
    reset_n = 1'b0;
    cs_n    = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    tx_load = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("init_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("init_busy", {31'd0, busy}, 32'd0);
    checkOutput("init_miso", {31'd0, miso}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte exchange
    p = rxPulses;
    loadTx(8'h3C);
    applyStimulus(1, 8'hF0, 8'h00, 8'h00, 4, 0, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_rx_data", {24'd0, rx_data}, 32'hF0);
    checkOutput("t1_master_rx", {24'd0, mRx[0]}, 32'h3C);
    checkOutput("t1_pulses", rxPulses - p, 32'd1);

    // Partial byte aborted by cs_n rise
    p = rxPulses;
    applyStimulus(1, 8'h0F, 8'h00, 8'h00, 4, 5, 1'b0, 1'b0, 8'h00);
    checkOutput("t2_rx_data_kept", {24'd0, rx_data}, 32'hF0);
    checkOutput("t2_pulses", rxPulses - p, 32'd0);

    // Two bytes back to back with a tx_buf reload during the first
    p = rxPulses;
    applyStimulus(2, 8'hA5, 8'h5A, 8'h00, 4, 0, 1'b0, 1'b1, 8'h11);
    checkOutput("t3_master_rx0", {24'd0, mRx[0]}, 32'h3C);
    checkOutput("t3_master_rx1", {24'd0, mRx[1]}, 32'h11);
    checkOutput("t3_rx_data", {24'd0, rx_data}, 32'h5A);
    checkOutput("t3_pulses", rxPulses - p, 32'd2);

    // sclk activity while deselected
    p = rxPulses;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (3) @(negedge clk);
    end
    checkOutput("t4_pulses", rxPulses - p, 32'd0);

    // Reset during bit 3, then a clean transfer
    loadTx(8'h96);
    applyStimulus(1, 8'hFF, 8'h00, 8'h00, 4, 3, 1'b1, 1'b0, 8'h00);
    applyStimulus(1, 8'h81, 8'h00, 8'h00, 4, 0, 1'b0, 1'b0, 8'h00);
    checkOutput("t5_rx_data", {24'd0, rx_data}, 32'h81);
    checkOutput("t5_master_rx", {24'd0, mRx[0]}, 32'h00);

    // First miso bit reflects the configured bit order
    loadTx(8'hA6);
    applyStimulus(1, 8'h01, 8'h00, 8'h00, 5, 0, 1'b0, 1'b0, 8'h00);
    checkOutput("t6_rx_data", {24'd0, rx_data}, 32'h01);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    checkOutput("t6_first_bit", {31'd0, mFirstBit}, 32'd0);
`else
    checkOutput("t6_first_bit", {31'd0, mFirstBit}, 32'd1);
`endif

    // Random transfers
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) loadTx(8'($urandom));
      n    = $urandom_range(1, 3);
      half = $urandom_range(4, 6);
      abortBits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8 * n - 1) : 0;
      applyStimulus(n, 8'($urandom), 8'($urandom), 8'($urandom), half, abortBits,
                    1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
